burst_feeder: RTL and testbench

- Upstream stage for the 8-word data buffer.
- Accepts 16-bit words one at a time over a valid/ready handshake and queues them in an internal FIFO.
- Once a full burst is queued, it pulses data_start for one cycle, then drives exactly BURST words on the following BURST cycles, aligned to the buffer's capture edges.
- Supports back-to-back bursts with no idle cycle.

---
 rtl/burst_feeder_if.sv | 26 ++
 rtl/burst_feeder.sv | 128 ++++++++++++
 tb/tb_burst_feeder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_feeder_if.sv
// Upstream word handshake plus the burst output toward the data buffer.
interface burst_feeder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             data_start;
  logic [WIDTH-1:0] data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  data_start,
    input  data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output data_start,
    output data
  );
endinterface

// File: rtl/burst_feeder.sv
// Burst feeder: queues upstream words in a FIFO and, once a full burst is
// available, emits a one-cycle data_start pulse followed by BURST words on
// consecutive cycles. Back-to-back bursts run with no idle cycle.
module burst_feeder #(
  parameter int WIDTH = 16,
  parameter int BURST = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  burst_feeder_if.slave            bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               burst_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [LW-1:0] BURST_LVL = LW'(BURST);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST);

  typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt, cnt_n;
  logic             start_r, start_n;
  logic [WIDTH-1:0] data_r, data_n;
  logic             busy_n;
  logic             push, pop, bc_inc;
  logic [LW-1:0]    level_pp;

  assign bus.in_ready   = (level < DEPTH_LVL);
  assign bus.data_start = start_r;
  assign bus.data       = data_r;
  assign push           = bus.in_valid && bus.in_ready;
  // Level including this cycle's push; only used on the no-pop final edge.
  assign level_pp       = level + LW'(push);

  // FIFO storage: contents are not reset, only the pointers are.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Next-state and burst sequencing.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start_n = 1'b0;
    data_n  = data_r;
    busy_n  = busy;
    pop     = 1'b0;
    bc_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        data_n = '0;
        if (level >= BURST_LVL) begin
          state_n = START;
          start_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      START: begin
        data_n  = mem[rd_ptr];
        pop     = 1'b1;
        cnt_n   = CW'(1);
        state_n = STREAM;
      end
      STREAM: begin
        if (cnt < BURST_CNT) begin
          data_n = mem[rd_ptr];
          pop    = 1'b1;
          cnt_n  = cnt + CW'(1);
        end else begin
          // Last word has been held a full cycle; chain directly into the
          // next burst if enough words are already queued.
          bc_inc = 1'b1;
          data_n = '0;
          if (level_pp >= BURST_LVL) begin
            start_n = 1'b1;
            state_n = START;
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, output registers, pointers, level and burst counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      start_r     <= 1'b0;
      data_r      <= '0;
      busy        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      burst_count <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      start_r <= start_n;
      data_r  <= data_n;
      busy    <= busy_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (bc_inc) burst_count <= burst_count + 8'd1;
    end
  end

  // A pop from an empty FIFO would mean the burst logic started too early.
  no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && level == '0));

endmodule

// File: tb/tb_burst_feeder.sv
// Scoreboard bench for burst_feeder: accepted words are queued as they are
// pushed, and a negedge monitor compares every streamed word, the FIFO level
// and in_ready against a bench-side occupancy model.
module tb_burst_feeder;
  localparam int WIDTH = 16;
  localparam int BURST = 8;
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [4:0] level;
  logic [7:0] burst_count;

  burst_feeder_if #(.WIDTH(WIDTH)) bus ();

  burst_feeder #(.WIDTH(WIDTH), .BURST(BURST), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .level       (level),
    .burst_count (burst_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  int start_q[$];
  int stream_left = 0;
  int mlevel = 0;
  int push_prev = 0;
  int saw_full = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: level model, in_ready, streamed words in FIFO order.
  always @(negedge clock) begin : mon
    int is_word;
    if (!reset_n) begin
      exp_q.delete();
      stream_left = 0;
      mlevel      = 0;
      push_prev   = 0;
    end else begin
      is_word = (stream_left > 0) ? 1 : 0;
      mlevel  = mlevel + push_prev - is_word;
      check("level", level, mlevel);
      if (is_word != 0) begin
        check("start_during_word", bus.data_start, 1'b0);
        check("busy_stream", busy, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_underrun actual=%0h required=queued_word", bus.data);
        end else begin
          check("word", bus.data, exp_q.pop_front());
        end
        stream_left--;
      end else begin
        check("idle_data", bus.data, 16'h0000);
        check("busy_idle", busy, bus.data_start);
        if (bus.data_start) begin
          stream_left = BURST;
          start_q.push_back(cyc);
        end
      end
      check("in_ready", bus.in_ready, (mlevel < DEPTH));
      if (!bus.in_ready) saw_full++;
      push_prev = (bus.in_valid && (mlevel < DEPTH)) ? 1 : 0;
      if (push_prev != 0) exp_q.push_back(bus.in_data);
    end
  end

  task automatic push_word(input logic [15:0] w);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clock);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=in_ready_low required=accept word=%0h", w);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (3) @(negedge clock);
    while (busy && n < 400) begin
      n++;
      @(negedge clock);
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int p;
    int n;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_data_start", bus.data_start, 1'b0);
    check("rst_data", bus.data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_burst_count", burst_count, 8'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    reset_n = 1'b1;
    idle_cycles(2);

    // Single burst 0x0001..0x0008.
    base = start_q.size();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    p = cyc;
    wait_idle("t1");
    check("t1_starts", start_q.size() - base, 1);
    if (start_q.size() > base) check("t1_start_cycle", start_q[base], p + 1);
    check("t1_burst_count", burst_count, 8'd1);
    check("t1_busy", busy, 1'b0);
    check("t1_level", level, 5'd0);

    // Sixteen words, two back-to-back bursts.
    base = start_q.size();
    p = 0;
    for (int i = 0; i < 16; i++) begin
      push_word(16'h0100 + 16'(i));
      if (i == 7) p = cyc;
    end
    wait_idle("t2");
    check("t2_starts", start_q.size() - base, 2);
    if (start_q.size() > base + 1) begin
      check("t2_first_start", start_q[base], p + 1);
      check("t2_b2b_gap", start_q[base+1] - start_q[base], BURST + 1);
    end
    check("t2_burst_count", burst_count, 8'd3);
    check("t2_level", level, 5'd0);

    // Sustained in_valid until the FIFO fills and back-pressure appears.
    saw_full = 0;
    for (int i = 0; i < 96; i++) push_word(16'h2000 + 16'(i));
    wait_idle("t3");
    check("t3_saw_full", (saw_full > 0), 1'b1);
    check("t3_burst_count", burst_count, 8'd15);
    check("t3_level", level, 5'd0);

    // Seven words then a stall: no burst until the eighth.
    base = start_q.size();
    for (int i = 0; i < 7; i++) push_word(16'h3000 + 16'(i));
    idle_cycles(20);
    check("t4_no_start", start_q.size() - base, 0);
    check("t4_level7", level, 5'd7);
    check("t4_busy", busy, 1'b0);
    push_word(16'h3007);
    p = cyc;
    wait_idle("t4");
    check("t4_starts", start_q.size() - base, 1);
    if (start_q.size() > base) check("t4_start_cycle", start_q[base], p + 1);
    check("t4_burst_count", burst_count, 8'd16);

    // Pointer wrap: leave 4 words queued so writes and reads cross the end.
    for (int i = 0; i < 12; i++) push_word(16'h4000 + 16'(i));
    wait_idle("t5a");
    check("t5_level_a", level, 5'd4);
    check("t5_bc_a", burst_count, 8'd17);
    for (int i = 0; i < 8; i++) push_word(16'h4100 + 16'(i));
    wait_idle("t5b");
    check("t5_level_b", level, 5'd4);
    check("t5_bc_b", burst_count, 8'd18);
    for (int i = 0; i < 4; i++) push_word(16'h4200 + 16'(i));
    wait_idle("t5c");
    check("t5_level_c", level, 5'd0);
    check("t5_bc_c", burst_count, 8'd19);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 8; i++) push_word(16'h5000 + 16'(i));
    n = 0;
    while (stream_left != 4 && n < 100) begin
      n++;
      @(posedge clock);
      #1;
    end
    check("t6_reached_word3", (stream_left == 4), 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_data", bus.data, 16'h0000);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_level", level, 5'd0);
    check("t6_async_start", bus.data_start, 1'b0);
    check("t6_async_bc", burst_count, 8'd0);
    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(1);
    base = start_q.size();
    for (int i = 0; i < 7; i++) push_word(16'h6000 + 16'(i));
    idle_cycles(10);
    check("t6_no_start", start_q.size() - base, 0);
    check("t6_level7", level, 5'd7);
    push_word(16'h6007);
    p = cyc;
    wait_idle("t6");
    check("t6_starts", start_q.size() - base, 1);
    if (start_q.size() > base) check("t6_start_cycle", start_q[base], p + 1);
    check("t6_burst_count", burst_count, 8'd1);
    check("t6_level", level, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
